// File: rtl/nios_led3_cpu_ocimem_arbiter_pkg.sv
// Shared definitions for the OCI RAM arbiter: widths, jdo field positions and FSM/op encodings.
package nios_led3_cpu_ocimem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 32;

  localparam int unsigned JDO_ADDR_HI  = 33;
  localparam int unsigned JDO_ADDR_LO  = 26;
  localparam int unsigned JDO_WDATA_HI = 34;
  localparam int unsigned JDO_WDATA_LO = 3;
  localparam int unsigned JDO_RD_BIT   = 17;

  typedef enum logic [1:0] {
    StIdle,
    StJtagRd,
    StCpuRd,
    StCpuAck
  } state_e;

  typedef enum logic {
    OpRd,
    OpWr
  } pend_op_e;

endpackage

// File: rtl/nios_led3_cpu_ocimem_jtag_cmd.sv
// JTAG command capture: strobe priority, one-deep pending buffer, MonAReg and overrun flag.
module nios_led3_cpu_ocimem_jtag_cmd
  import nios_led3_cpu_ocimem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              fsm_idle,
  output logic              pend,
  output pend_op_e          pend_op,
  output logic [DATA_W-1:0] pend_wdata,
  output logic [ADDR_W-1:0] mon_a_reg,
  output logic              issue,
  output logic              queue_any,
  output logic              queue_rd,
  output logic              jtag_overrun
);

  logic sel_a, sel_na, sel_b, any_strobe, prio_drop, can_take, take, queue_wr;
  logic unused_jdo;

  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  always_comb begin
    issue      = fsm_idle & pend;
    sel_a      = take_action_ocimem_a;
    sel_na     = ~take_action_ocimem_a & take_no_action_ocimem_a;
    sel_b      = ~take_action_ocimem_a & ~take_no_action_ocimem_a & take_action_ocimem_b;
    any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    prio_drop  = (take_action_ocimem_a & (take_no_action_ocimem_a | take_action_ocimem_b)) |
                 (take_no_action_ocimem_a & take_action_ocimem_b);
    // The buffer slot frees up in the same cycle its occupant is issued.
    can_take   = ~pend | issue;
    take       = any_strobe & can_take;
    queue_rd   = take & ((sel_a & jdo[JDO_RD_BIT]) | sel_na);
    queue_wr   = take & sel_b;
    queue_any  = queue_rd | queue_wr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend         <= 1'b0;
      pend_op      <= OpRd;
      pend_wdata   <= '0;
      mon_a_reg    <= '0;
      jtag_overrun <= 1'b0;
    end else begin
      if (queue_any) begin
        pend       <= 1'b1;
        pend_op    <= queue_wr ? OpWr : OpRd;
        pend_wdata <= DATA_W'(jdo[JDO_WDATA_HI:JDO_WDATA_LO]);
      end else if (issue) begin
        pend <= 1'b0;
      end
      // An address load overrides the post-issue increment.
      if (take & sel_a) begin
        mon_a_reg <= ADDR_W'(jdo[JDO_ADDR_HI:JDO_ADDR_LO]);
      end else if (issue) begin
        mon_a_reg <= mon_a_reg + 1'b1;
      end
      if (prio_drop | (any_strobe & ~can_take)) begin
        jtag_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/nios_led3_cpu_ocimem_arbiter.sv
// Shares the single-port OCI RAM between buffered JTAG commands (priority) and the CPU Avalon port.
module nios_led3_cpu_ocimem_arbiter
  import nios_led3_cpu_ocimem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic [3:0]        avs_byteenable,
  input  logic              avs_debugaccess,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [3:0]        ram_byteenable,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              jtag_overrun
);

  state_e            state_q;
  logic              pend, issue, queue_any, queue_rd, cpu_go;
  pend_op_e          pend_op;
  logic [DATA_W-1:0] pend_wdata;

  nios_led3_cpu_ocimem_jtag_cmd #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_jtag_cmd (
    .clk                    (clk),
    .reset_n                (reset_n),
    .jdo                    (jdo),
    .take_action_ocimem_a   (take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b   (take_action_ocimem_b),
    .fsm_idle               (state_q == StIdle),
    .pend                   (pend),
    .pend_op                (pend_op),
    .pend_wdata             (pend_wdata),
    .mon_a_reg              (MonAReg),
    .issue                  (issue),
    .queue_any              (queue_any),
    .queue_rd               (queue_rd),
    .jtag_overrun           (jtag_overrun)
  );

  // A strobe captured this cycle must be issued before the CPU gets the RAM.
  assign cpu_go = (state_q == StIdle) & ~pend & ~queue_any & (avs_read | avs_write);

  always_comb begin
    ram_addr       = MonAReg;
    ram_wren       = 1'b0;
    ram_byteenable = 4'hF;
    ram_wdata      = pend_wdata;
    if (issue) begin
      ram_wren = (pend_op == OpWr);
    end else if (cpu_go) begin
      ram_addr       = avs_address;
      ram_byteenable = avs_byteenable;
      ram_wdata      = avs_writedata;
      ram_wren       = ~avs_read & avs_write & avs_debugaccess;
    end
  end

  assign avs_readdata    = (state_q == StCpuRd) ? ram_rdata : '0;
  assign avs_waitrequest = (avs_read | avs_write) & ~(state_q inside {StCpuRd, StCpuAck});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (issue) begin
            if (pend_op == OpRd) state_q <= StJtagRd;
          end else if (cpu_go) begin
            state_q <= avs_read ? StCpuRd : StCpuAck;
          end
        end
        StJtagRd: begin
          MonDReg <= ram_rdata;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      // Stay not-ready while another read is still buffered behind the one landing now.
      if (queue_rd) begin
        monitor_ready <= 1'b0;
      end else if ((state_q == StJtagRd) && !(pend && (pend_op == OpRd))) begin
        monitor_ready <= 1'b1;
      end
    end
  end

endmodule
